// File: rtl/midori64_round_key_sched.sv
// Midori64 round-key scheduler: latches WK/MK0/MK1 on start and streams
// WK, RK_0..RK_14, WK over a valid/next handshake, one key per accepted step.
module midori64_round_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] wk_in,
  input  logic [63:0] mk0_in,
  input  logic [63:0] mk1_in,
  input  logic        next,
  output logic [63:0] key_out,
  output logic        key_valid,
  output logic [4:0]  step,
  output logic        is_whiten,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [4:0] LastStep = 5'd16;

  state_e      state_q, state_d;
  logic [63:0] wk_q, wk_d;
  logic [63:0] mk0_q, mk0_d;
  logic [63:0] mk1_q, mk1_d;
  logic [63:0] key_q, key_d;
  logic [4:0]  step_q, step_d;
  logic        done_q, done_d;
  logic [63:0] rk;

  function automatic logic [15:0] alpha(input logic [3:0] idx);
    logic [15:0] c;
    case (idx)
      4'd0:    c = 16'h15B3;
      4'd1:    c = 16'h78C0;
      4'd2:    c = 16'hA435;
      4'd3:    c = 16'h6213;
      4'd4:    c = 16'h104F;
      4'd5:    c = 16'hD170;
      4'd6:    c = 16'h0266;
      4'd7:    c = 16'h0BCC;
      4'd8:    c = 16'h9481;
      4'd9:    c = 16'h40B8;
      4'd10:   c = 16'h7197;
      4'd11:   c = 16'h228E;
      4'd12:   c = 16'h5130;
      4'd13:   c = 16'hF8CA;
      4'd14:   c = 16'hDF90;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Constant bit 15-k lands in the LSB of nibble k (nibble 0 is the top nibble).
  function automatic logic [63:0] expand(input logic [15:0] c);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[60 - 4 * k] = c[15 - k];
    end
    return r;
  endfunction

  // Key for step step_q+1 when step_q is 0..14, i.e. RK_i with i = step_q.
  assign rk = (step_q[0] ? mk1_q : mk0_q) ^ expand(alpha(step_q[3:0]));

  always_comb begin
    state_d = state_q;
    wk_d    = wk_q;
    mk0_d   = mk0_q;
    mk1_d   = mk1_q;
    key_d   = key_q;
    step_d  = step_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          wk_d    = wk_in;
          mk0_d   = mk0_in;
          mk1_d   = mk1_in;
          key_d   = wk_in;
          step_d  = 5'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (next) begin
          if (step_q == LastStep) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 5'd1;
            key_d  = (step_q == 5'd15) ? wk_q : rk;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wk_q    <= '0;
      mk0_q   <= '0;
      mk1_q   <= '0;
      key_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wk_q    <= wk_d;
      mk0_q   <= mk0_d;
      mk1_q   <= mk1_d;
      key_q   <= key_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = key_q;
  assign key_valid = (state_q == StRun);
  assign busy      = key_valid;
  assign step      = step_q;
  assign is_whiten = key_valid && ((step_q == 5'd0) || (step_q == LastStep));
  assign done      = done_q;

endmodule

// File: tb/tb_midori64_round_key_sched.sv
// Self-checking bench for midori64_round_key_sched against a table-driven key model.
module tb_midori64_round_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        next;
  logic [63:0] wk_in, mk0_in, mk1_in;
  logic [63:0] key_out;
  logic        key_valid, is_whiten, busy, done;
  logic [4:0]  step;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] ALPHA [15] = '{
    16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F, 16'hD170, 16'h0266, 16'h0BCC,
    16'h9481, 16'h40B8, 16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90
  };

  midori64_round_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wk_in     (wk_in),
    .mk0_in    (mk0_in),
    .mk1_in    (mk1_in),
    .next      (next),
    .key_out   (key_out),
    .key_valid (key_valid),
    .step      (step),
    .is_whiten (is_whiten),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Each binary digit of alpha becomes one hex digit, MSB first.
  function automatic logic [63:0] model_key(input logic [63:0] wk, input logic [63:0] mk0,
                                            input logic [63:0] mk1, input int s);
    logic [63:0] spread;
    logic [15:0] c;
    if (s == 0 || s == 16) return wk;
    c = ALPHA[s - 1];
    spread = '0;
    for (int j = 0; j < 16; j++) spread |= 64'((c >> j) & 16'h1) << (4 * j);
    return (((s - 1) % 2) == 0 ? mk0 : mk1) ^ spread;
  endfunction

  task automatic test_reset_values();
    @(negedge clk);
    n_tests++;
    if ({key_out, key_valid, busy, step, is_whiten, done} !== 73'd0) begin
      n_fail++;
      $display("FAIL reset_values got key=%h v=%b b=%b s=%0d w=%b d=%b, want all 0",
               key_out, key_valid, busy, step, is_whiten, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_key();
    logic [63:0] exp;
    logic [63:0] lit;
    @(negedge clk);
    wk_in = '0; mk0_in = '0; mk1_in = '0; start = 1'b1; next = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s <= 16; s++) begin
      if (s > 0) @(negedge clk);
      exp = model_key('0, '0, '0, s);
      n_tests++;
      if (step !== 5'(s) || key_out !== exp || key_valid !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_key step %0d got s=%0d key=%h v=%b d=%b, want key=%h v=1 d=0",
                 s, step, key_out, key_valid, done, exp);
      end
      if (s == 1 || s == 2 || s == 15) begin
        lit = (s == 1) ? 64'h0001010110110011 :
              (s == 2) ? 64'h0111100011000000 : 64'h1101111110010000;
        n_tests++;
        if (key_out !== lit) begin
          n_fail++;
          $display("FAIL zero_key_const step %0d got %h want %h", s, key_out, lit);
        end
      end
    end
    @(negedge clk);
    next = 1'b0;
    n_tests++;
    if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0 || key_out !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_key_done got d=%b v=%b b=%b key=%h, want d=1 v=0 b=0 key=0",
               done, key_valid, busy, key_out);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_key_done_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_nonzero_key();
    logic [63:0] wk, mk0, mk1, exp;
    logic        exp_w;
    wk = 64'hFFFFFFFFFFFFFFFF; mk0 = 64'h0123456789ABCDEF; mk1 = 64'hFEDCBA9876543210;
    wk_in = wk; mk0_in = mk0; mk1_in = mk1; start = 1'b1; next = 1'b0;
    @(negedge clk);
    start = 1'b0; next = 1'b1;
    for (int s = 0; s <= 16; s++) begin
      if (s > 0) @(negedge clk);
      exp   = model_key(wk, mk0, mk1, s);
      exp_w = (s == 0 || s == 16);
      n_tests++;
      if (step !== 5'(s) || key_out !== exp || is_whiten !== exp_w) begin
        n_fail++;
        $display("FAIL nonzero_key step %0d got s=%0d key=%h w=%b, want key=%h w=%b",
                 s, step, key_out, is_whiten, exp, exp_w);
      end
      if (s <= 2) begin
        exp = (s == 0) ? 64'hFFFFFFFFFFFFFFFF :
              (s == 1) ? 64'h0122446699BACDFE : 64'hFFCDAA9867543210;
        n_tests++;
        if (key_out !== exp) begin
          n_fail++;
          $display("FAIL nonzero_key_const step %0d got %h want %h", s, key_out, exp);
        end
      end
    end
    @(negedge clk);
    next = 1'b0;
    n_tests++;
    if (done !== 1'b1 || key_out !== wk) begin
      n_fail++;
      $display("FAIL nonzero_key_done got d=%b key=%h want d=1 key=%h", done, key_out, wk);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [63:0] wk, mk0, mk1, exp;
    wk = rand64(); mk0 = rand64(); mk1 = rand64();
    wk_in = wk; mk0_in = mk0; mk1_in = mk1; start = 1'b1; next = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 1; s <= 4; s++) @(negedge clk);
    next = 1'b0;
    exp = model_key(wk, mk0, mk1, 4);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_tests++;
      if (step !== 5'd4 || key_out !== exp || key_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got s=%0d key=%h v=%b, want s=4 key=%h v=1",
                 h, step, key_out, key_valid, exp);
      end
    end
    next = 1'b1;
    for (int s = 5; s <= 16; s++) begin
      @(negedge clk);
      exp = model_key(wk, mk0, mk1, s);
      n_tests++;
      if (step !== 5'(s) || key_out !== exp) begin
        n_fail++;
        $display("FAIL stall_resume step %0d got s=%0d key=%h want key=%h",
                 s, step, key_out, exp);
      end
    end
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_inputs();
    logic [63:0] wk, mk0, mk1, exp;
    int exp_s;
    wk = rand64(); mk0 = rand64(); mk1 = rand64();
    wk_in = wk; mk0_in = mk0; mk1_in = mk1; start = 1'b1; next = 1'b0;
    @(negedge clk);
    exp_s = 0;
    for (int c = 0; c < 18; c++) begin
      exp = model_key(wk, mk0, mk1, exp_s);
      n_tests++;
      if (step !== 5'(exp_s) || key_out !== exp || key_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ignored_inputs cycle %0d got s=%0d key=%h v=%b, want s=%0d key=%h",
                 c, step, key_out, key_valid, exp_s, exp);
      end
      wk_in = rand64(); mk0_in = rand64(); mk1_in = rand64();
      start = (c == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      next  = (c != 3);
      @(negedge clk);
      if (c != 3) exp_s++;
    end
    start = 1'b0; next = 1'b0;
    n_tests++;
    if (done !== 1'b1 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_inputs_done got d=%b v=%b want d=1 v=0", done, key_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] wk, mk0, mk1, exp;
    wk_in = rand64(); mk0_in = rand64(); mk1_in = rand64(); start = 1'b1; next = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 1; s <= 17; s++) @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_done got done=%b want 1", done);
    end
    wk = rand64(); mk0 = rand64(); mk1 = rand64();
    wk_in = wk; mk0_in = mk0; mk1_in = mk1; start = 1'b1;
    for (int s = 0; s <= 16; s++) begin
      @(negedge clk);
      start = 1'b0;
      exp = model_key(wk, mk0, mk1, s);
      n_tests++;
      if (step !== 5'(s) || key_out !== exp || key_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_second step %0d got s=%0d key=%h v=%b, want key=%h v=1",
                 s, step, key_out, key_valid, exp);
      end
    end
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] wk;
    wk_in = rand64(); mk0_in = rand64(); mk1_in = rand64(); start = 1'b1; next = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 1; s <= 7; s++) @(negedge clk);
    n_tests++;
    if (step !== 5'd7) begin
      n_fail++;
      $display("FAIL reset_setup got step=%0d want 7", step);
    end
    next = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({key_out, key_valid, busy, step, is_whiten, done} !== 73'd0) begin
      n_fail++;
      $display("FAIL reset_async got key=%h v=%b b=%b s=%0d w=%b d=%b, want all 0",
               key_out, key_valid, busy, step, is_whiten, done);
    end
    @(negedge clk);
    rst = 1'b0; next = 1'b1;
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b0 || step !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_idle got v=%b s=%0d want v=0 s=0", key_valid, step);
    end
    wk = rand64();
    wk_in = wk; start = 1'b1; next = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (key_valid !== 1'b1 || step !== 5'd0 || key_out !== wk) begin
      n_fail++;
      $display("FAIL reset_restart got v=%b s=%0d key=%h want v=1 s=0 key=%h",
               key_valid, step, key_out, wk);
    end
    next = 1'b1;
    for (int s = 1; s <= 17; s++) @(negedge clk);
    next = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] wk, mk0, mk1, exp;
    logic        exp_valid, exp_done, exp_w;
    int          exp_s;
    for (int run = 0; run < 6; run++) begin
      wk = rand64(); mk0 = rand64(); mk1 = rand64();
      wk_in = wk; mk0_in = mk0; mk1_in = mk1; start = 1'b1;
      next = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      exp_valid = 1'b1; exp_done = 1'b0; exp_s = 0;
      for (int c = 0; c < 200; c++) begin
        exp   = model_key(wk, mk0, mk1, exp_s);
        exp_w = exp_valid && (exp_s == 0 || exp_s == 16);
        n_tests++;
        if (key_valid !== exp_valid || busy !== exp_valid || done !== exp_done ||
            step !== 5'(exp_s) || key_out !== exp || is_whiten !== exp_w) begin
          n_fail++;
          $display("FAIL random run %0d cycle %0d got v=%b d=%b s=%0d key=%h w=%b, %s%b %0d %h %b",
                   run, c, key_valid, done, step, key_out, is_whiten, "want v/s/key/w ",
                   exp_valid, exp_s, exp, exp_w);
        end
        if (!exp_valid) break;
        next  = ($urandom_range(0, 3) != 0);
        start = 1'($urandom_range(0, 1));
        wk_in = rand64(); mk0_in = rand64(); mk1_in = rand64();
        exp_done = 1'b0;
        if (next) begin
          if (exp_s == 16) begin
            exp_valid = 1'b0;
            exp_done  = 1'b1;
          end else begin
            exp_s++;
          end
        end
        @(negedge clk);
      end
      start = 1'b0; next = 1'b0;
      n_tests++;
      if (exp_valid) begin
        n_fail++;
        $display("FAIL random_timeout run %0d never completed", run);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; next = 1'b0;
    wk_in = '0; mk0_in = '0; mk1_in = '0;
    test_reset_values();
    test_zero_key();
    test_nonzero_key();
    test_stall();
    test_ignored_inputs();
    test_back_to_back();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
